// File: rtl/rom_burst_reader.sv
// rom_burst_reader: streams a burst of consecutive words from a 1-cycle
// registered ROM into a 2-entry output buffer with ready/valid backpressure.
// Ports:
//   clk, reset            - single clock, synchronous active-high reset
//   start, start_addr,    - burst request (sampled in IDLE only), first address,
//   burst_len               and word count minus 1
//   rom_addr, rom_data    - ROM address (registered), ROM data one cycle later
//   dout, dout_valid,     - buffer head, valid flag, consumer accept
//   dout_ready
//   busy, done            - burst in progress, one-cycle completion pulse
module rom_burst_reader #(
  parameter int unsigned datawidth    = 8,
  parameter int unsigned addresswidth = 10
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [addresswidth-1:0] start_addr,
  input  logic [addresswidth-1:0] burst_len,
  output logic [addresswidth-1:0] rom_addr,
  input  logic [datawidth-1:0]    rom_data,
  output logic [datawidth-1:0]    dout,
  output logic                    dout_valid,
  input  logic                    dout_ready,
  output logic                    busy,
  output logic                    done
);

  localparam int unsigned CNT_W = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [addresswidth-1:0] rom_addr_q, rom_addr_d;
  logic [addresswidth-1:0] remaining_q, remaining_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic                    inflight_q, inflight_d;
  logic [datawidth-1:0]    head_q, head_d;
  logic [datawidth-1:0]    tail_q, tail_d;
  logic                    dout_valid_q, dout_valid_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;

  logic push;
  logic pop;
  logic issue;

  // Next-state, FIFO and address generation
  always_comb begin
    state_d      = state_q;
    rom_addr_d   = rom_addr_q;
    remaining_d  = remaining_q;
    count_d      = count_q;
    inflight_d   = 1'b0;
    head_d       = head_q;
    tail_d       = tail_q;
    done_d       = 1'b0;
    dout_valid_d = dout_valid_q;
    busy_d       = busy_q;

    push = inflight_q;
    pop  = dout_valid_q & dout_ready;
    // count + inflight - pop < 2, rearranged to avoid a negative intermediate
    issue = (state_q == READ) &&
            ((3'(count_q) + 3'(inflight_q)) < (3'd2 + 3'(pop)));

    // Head/tail pair: head is always the oldest word, tail the newer one
    case ({push, pop})
      2'b10: begin
        if (count_q == 2'd0) head_d = rom_data;
        else                 tail_d = rom_data;
      end
      2'b01: head_d = tail_q;
      2'b11: begin
        if (count_q == 2'd1) begin
          head_d = rom_data;
        end else begin
          head_d = tail_q;
          tail_d = rom_data;
        end
      end
      default: ;
    endcase
    count_d = CNT_W'(count_q + CNT_W'(push) - CNT_W'(pop));

    case (state_q)
      IDLE: begin
        if (start) begin
          rom_addr_d  = start_addr;
          remaining_d = burst_len;
          state_d     = READ;
        end
      end
      READ: begin
        if (issue) begin
          inflight_d = 1'b1;
          if (remaining_q != '0) begin
            rom_addr_d  = rom_addr_q + addresswidth'(1);
            remaining_d = remaining_q - addresswidth'(1);
          end else begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        // Leave once the buffer empties at this edge with nothing in flight
        if ((count_d == '0) && !inflight_q) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    dout_valid_d = (count_d != '0);
    busy_d       = (state_d != IDLE);
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      rom_addr_q   <= '0;
      remaining_q  <= '0;
      count_q      <= '0;
      inflight_q   <= 1'b0;
      head_q       <= '0;
      tail_q       <= '0;
      dout_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      rom_addr_q   <= rom_addr_d;
      remaining_q  <= remaining_d;
      count_q      <= count_d;
      inflight_q   <= inflight_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      dout_valid_q <= dout_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign rom_addr   = rom_addr_q;
  assign dout       = head_q;
  assign dout_valid = dout_valid_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule
